face_scan_ctrl: RTL and testbench

- Sequences one cube-face colour scan on the DE2 CCD path.
- On `Start`, pulses `gc` to the centre calculator and waits for its registered centre coordinates.
- Then issues four pixel-sample requests around each of the 9 block centres to the frame-buffer sampler and averages each group of four.
- Presents 9 averaged RGB facelet values to the colour classifier, with a `Done` pulse at the end.

---
 rtl/face_scan_pkg.sv | 36 +++
 rtl/rgb_avg4.sv | 48 ++++
 rtl/face_scan_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_face_scan_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_scan_pkg.sv
// Shared types and constants for the cube-face colour scan sequencer.
package face_scan_pkg;

    localparam int NUM_BLOCKS           = 9;
    localparam int COORD_W              = 11;
    localparam int CW_DEFAULT           = 10;
    localparam int SAMP_TIMEOUT_DEFAULT = 255;

    localparam logic [COORD_W-1:0] COORD_MAX = 11'h7FF;

    // Bit s of each mask is the offset applied for sub-sample s:
    // s=0 (0,0), s=1 (+1,0), s=2 (0,+1), s=3 (+1,+1).
    localparam logic [3:0] OFFSET_X = 4'b1010;
    localparam logic [3:0] OFFSET_Y = 4'b1100;

    typedef logic [3*CW_DEFAULT-1:0] rgb_t;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAITC,
        REQ,
        GAP,
        DONE
    } state_t;

    // Adds a 0/1 offset to a coordinate, clamping at the top of the range
    // so a centre on the right/bottom edge never wraps to 0.
    function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] base,
                                                   input logic               off);
        logic [COORD_W:0] sum;
        sum = {1'b0, base} + {{COORD_W{1'b0}}, off};
        return sum[COORD_W] ? COORD_MAX : sum[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/rgb_avg4.sv
// Three-channel accumulator that sums four samples and presents their
// truncated average (sum >> 2) per channel.
module rgb_avg4 #(
    parameter int CW = 10
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            add_i,
    input  logic [3*CW-1:0] sample_i,
    output logic [3*CW-1:0] avg_o
);

    localparam int AW = CW + 2;

    logic [2:0][AW-1:0] acc_q;
    logic [2:0][AW-1:0] acc_d;

    // Clear wins over add; otherwise each channel adds its slice of the sample.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (add_i) begin
            for (int c = 0; c < 3; c++) begin
                acc_d[c] = acc_q[c] + AW'(sample_i[c*CW +: CW]);
            end
        end
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Dropping the two low bits divides the four-sample sum by four.
    always_comb begin
        avg_o = '0;
        for (int c = 0; c < 3; c++) begin
            avg_o[c*CW +: CW] = acc_q[c][AW-1:2];
        end
    end

endmodule

// File: rtl/face_scan_ctrl.sv
// Sequences one cube-face scan: triggers the centre calculator, samples a
// 2x2 pixel patch at each of the nine block centres and publishes the
// averaged colour of every facelet, ending with a one-cycle Done pulse.
module face_scan_ctrl
    import face_scan_pkg::*;
#(
    parameter int SAMP_TIMEOUT = SAMP_TIMEOUT_DEFAULT,
    parameter int CW           = CW_DEFAULT
) (
    input  logic                                 Clk,
    input  logic                                 Reset_N,
    input  logic                                 Start,
    output logic                                 gc,
    input  logic                                 gotCenters,
    input  logic [NUM_BLOCKS-1:0][COORD_W-1:0]   CentersX,
    input  logic [NUM_BLOCKS-1:0][COORD_W-1:0]   CentersY,
    output logic                                 Samp_Req,
    output logic [COORD_W-1:0]                   Samp_X,
    output logic [COORD_W-1:0]                   Samp_Y,
    input  logic                                 Samp_Ack,
    input  logic [3*CW-1:0]                      Samp_RGB,
    output logic [NUM_BLOCKS-1:0][3*CW-1:0]      Face_RGB,
    output logic                                 Busy,
    output logic                                 Done,
    output logic                                 Timeout_Err
);

    localparam int               TW       = $clog2(SAMP_TIMEOUT + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(SAMP_TIMEOUT - 1);

    state_t                            state_q, state_d;
    logic [3:0]                        blk_q, blk_d;
    logic [1:0]                        sub_q, sub_d;
    logic [TW-1:0]                     tmo_q, tmo_d;
    logic                              seen_q, seen_d;
    logic                              tmoErr_q, tmoErr_d;
    logic [COORD_W-1:0]                sampX_q, sampX_d;
    logic [COORD_W-1:0]                sampY_q, sampY_d;
    logic [NUM_BLOCKS-1:0][3*CW-1:0]   face_q, face_d;
    logic [COORD_W-1:0]                selX, selY;
    logic                              accClear, accAdd;
    logic [3*CW-1:0]                   avg;

    rgb_avg4 #(
        .CW(CW)
    ) u_avg (
        .clk_i   (Clk),
        .rst_ni  (Reset_N),
        .clear_i (accClear),
        .add_i   (accAdd),
        .sample_i(Samp_RGB),
        .avg_o   (avg)
    );

    // Next-state logic. A sample is considered finished on ack or timeout;
    // the GAP state that follows keeps Samp_Req low for a cycle and, after
    // the fourth sample, stores the block average. Coordinates are loaded
    // from the next-state block/sub-sample whenever REQ is entered so they
    // stay stable for the whole request.
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        sub_d    = sub_q;
        tmo_d    = tmo_q;
        seen_d   = seen_q;
        tmoErr_d = tmoErr_q;
        sampX_d  = sampX_q;
        sampY_d  = sampY_q;
        face_d   = face_q;
        accClear = 1'b0;
        accAdd   = 1'b0;
        selX     = '0;
        selY     = '0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = CALC;
                    blk_d    = '0;
                    sub_d    = '0;
                    tmoErr_d = 1'b0;
                    accClear = 1'b1;
                end
            end
            CALC: begin
                seen_d  = 1'b0;
                state_d = WAITC;
            end
            WAITC: begin
                // gotCenters may still be high from the previous scan, so
                // proceed only one full cycle after it was first observed.
                if (seen_q) begin
                    state_d = REQ;
                end else if (gotCenters) begin
                    seen_d = 1'b1;
                end
            end
            REQ: begin
                if (Samp_Ack) begin
                    accAdd  = 1'b1;
                    sub_d   = sub_q + 2'd1;
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    tmoErr_d = 1'b1;
                    sub_d    = sub_q + 2'd1;
                    state_d  = GAP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            GAP: begin
                state_d = REQ;
                if (sub_q == 2'd0) begin
                    for (int i = 0; i < NUM_BLOCKS; i++) begin
                        if (blk_q == 4'(i)) begin
                            face_d[i] = avg;
                        end
                    end
                    accClear = 1'b1;
                    if (blk_q == 4'(NUM_BLOCKS - 1)) begin
                        state_d = DONE;
                    end else begin
                        blk_d = blk_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (blk_d == 4'(i)) begin
                selX = CentersX[i];
                selY = CentersY[i];
            end
        end

        if (state_d == REQ && state_q != REQ) begin
            tmo_d   = '0;
            sampX_d = sat_add(selX, OFFSET_X[sub_d]);
            sampY_d = sat_add(selY, OFFSET_Y[sub_d]);
        end
    end

    // State and datapath registers; reset abandons any scan in progress.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            sub_q    <= '0;
            tmo_q    <= '0;
            seen_q   <= 1'b0;
            tmoErr_q <= 1'b0;
            sampX_q  <= '0;
            sampY_q  <= '0;
            face_q   <= '0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            sub_q    <= sub_d;
            tmo_q    <= tmo_d;
            seen_q   <= seen_d;
            tmoErr_q <= tmoErr_d;
            sampX_q  <= sampX_d;
            sampY_q  <= sampY_d;
            face_q   <= face_d;
        end
    end

    // Strobes decode straight from the registered state, so they are glitch
    // free and read 0 as soon as reset has forced IDLE.
    always_comb begin
        gc          = (state_q == CALC);
        Samp_Req    = (state_q == REQ);
        Done        = (state_q == DONE);
        Busy        = (state_q != IDLE);
        Samp_X      = sampX_q;
        Samp_Y      = sampY_q;
        Face_RGB    = face_q;
        Timeout_Err = tmoErr_q;
    end

endmodule

// File: tb/tb_face_scan_ctrl.sv
// Scoreboard bench for face_scan_ctrl: scans are launched with chosen or
// random centres and sampler behaviour, expected requests and face colours
// are queued from a plain-arithmetic model, and a monitor compares them.
module tb_face_scan_ctrl;
    import face_scan_pkg::*;

    localparam int TMO = SAMP_TIMEOUT_DEFAULT;
    localparam int NS  = NUM_BLOCKS * 4;

    typedef logic [NUM_BLOCKS-1:0][3*CW_DEFAULT-1:0] face_t;
    typedef struct {
        int x;
        int y;
        int dur;
    } req_t;

    logic                                      Clk;
    logic                                      Reset_N;
    logic                                      Start;
    logic                                      gc;
    logic                                      gotCenters;
    logic [NUM_BLOCKS-1:0][COORD_W-1:0]        CentersX;
    logic [NUM_BLOCKS-1:0][COORD_W-1:0]        CentersY;
    logic                                      Samp_Req;
    logic [COORD_W-1:0]                        Samp_X;
    logic [COORD_W-1:0]                        Samp_Y;
    logic                                      Samp_Ack;
    logic [3*CW_DEFAULT-1:0]                   Samp_RGB;
    logic [NUM_BLOCKS-1:0][3*CW_DEFAULT-1:0]   Face_RGB;
    logic                                      Busy;
    logic                                      Done;
    logic                                      Timeout_Err;

    int   cenX [NUM_BLOCKS];
    int   cenY [NUM_BLOCKS];
    rgb_t rgbTab [NS];
    int   waitTab [NS];
    bit   lateTab [NS];

    req_t  expReqQ [$];
    face_t expFaceQ [$];
    bit    expErrQ [$];

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    int doneCycle   = 0;
    int reqSeen     = 0;
    int cycle       = 0;

    face_scan_ctrl #(
        .SAMP_TIMEOUT(TMO),
        .CW          (CW_DEFAULT)
    ) dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .Start      (Start),
        .gc         (gc),
        .gotCenters (gotCenters),
        .CentersX   (CentersX),
        .CentersY   (CentersY),
        .Samp_Req   (Samp_Req),
        .Samp_X     (Samp_X),
        .Samp_Y     (Samp_Y),
        .Samp_Ack   (Samp_Ack),
        .Samp_RGB   (Samp_RGB),
        .Face_RGB   (Face_RGB),
        .Busy       (Busy),
        .Done       (Done),
        .Timeout_Err(Timeout_Err)
    );

    // Free-running clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Cycle counter used for latency measurements.
    always @(posedge Clk) cycle <= cycle + 1;

    // Hard stop in case the bench itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at actual=%0d cycles, required fewer", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: every request in scan order with its clamped
    // coordinates and expected Samp_Req high time, then the nine averages.
    task automatic buildExpect();
        face_t f;
        bit    err;
        req_t  r;
        int    i, sr, sg, sb;
        err = 1'b0;
        f   = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            sr = 0;
            sg = 0;
            sb = 0;
            for (int s = 0; s < 4; s++) begin
                i   = b * 4 + s;
                r.x = cenX[b] + (s % 2);
                r.y = cenY[b] + (s / 2);
                if (r.x > 2047) r.x = 2047;
                if (r.y > 2047) r.y = 2047;
                if (waitTab[i] >= 0 && waitTab[i] < TMO) begin
                    r.dur = waitTab[i] + 1;
                    sr += int'(rgbTab[i][29:20]);
                    sg += int'(rgbTab[i][19:10]);
                    sb += int'(rgbTab[i][9:0]);
                end else begin
                    r.dur = TMO;
                    err   = 1'b1;
                end
                expReqQ.push_back(r);
            end
            f[b] = {10'(sr / 4), 10'(sg / 4), 10'(sb / 4)};
        end
        expFaceQ.push_back(f);
        expErrQ.push_back(err);
    endtask

    task automatic randomTables(input int maxWait);
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            cenX[b] = $urandom_range(0, 2047);
            cenY[b] = $urandom_range(0, 2047);
        end
        for (int i = 0; i < NS; i++) begin
            rgbTab[i]  = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                          10'($urandom_range(0, 1023))};
            waitTab[i] = $urandom_range(0, maxWait);
            lateTab[i] = 1'b0;
        end
    endtask

    task automatic driveCenters();
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            CentersX[b] = 11'(cenX[b]);
            CentersY[b] = 11'(cenY[b]);
        end
    endtask

    task automatic doReset();
        @(posedge Clk);
        #2;
        Reset_N = 1'b0;
        Start   = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("rst_gc", gc, 0);
        checkOutput("rst_samp_req", Samp_Req, 0);
        checkOutput("rst_samp_x", Samp_X, 0);
        checkOutput("rst_samp_y", Samp_Y, 0);
        checkOutput("rst_face_rgb_nonzero", (Face_RGB != '0), 0);
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_done", Done, 0);
        checkOutput("rst_timeout_err", Timeout_Err, 0);
        Reset_N = 1'b1;
        expReqQ.delete();
        expFaceQ.delete();
        expErrQ.delete();
    endtask

    // Launches one scan and waits (bounded) for its Done. With holdStart the
    // Start line is raised mid-scan and kept high through the DONE cycle.
    task automatic applyStimulus(input int budget, input bit holdStart, output int lat);
        int startDone;
        int n;
        int t0;
        startDone = doneCount;
        n         = 0;
        lat       = -1;
        driveCenters();
        buildExpect();
        @(posedge Clk);
        #1;
        Start = 1'b1;
        t0    = cycle;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        while (doneCount == startDone && n < budget) begin
            @(posedge Clk);
            #1;
            n++;
            Start = holdStart && (n >= 30);
        end
        Start = 1'b0;
        checkOutput("done_within_budget", (doneCount != startDone), 1);
        if (doneCount != startDone) lat = doneCycle - (t0 + 1);
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("busy_low_after_done", Busy, 0);
        checkOutput("done_pulses_per_scan", doneCount - startDone, 1);
        if (Busy || doneCount == startDone) doReset();
    endtask

    // Centre calculator stand-in: raises gotCenters the cycle after the
    // first gc and, like the real one, never drops it again.
    initial begin : centreCalc
        gotCenters = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (gc) begin
                @(posedge Clk);
                #1;
                gotCenters = 1'b1;
            end
        end
    end

    // Frame-buffer sampler stand-in: acks request idx after waitTab[idx]
    // cycles (negative means never) and optionally sends a stray ack just
    // after an abandoned request has dropped.
    initial begin : responder
        int idx;
        int wc;
        bit acked;
        bit prev;
        idx      = 0;
        wc       = 0;
        acked    = 1'b0;
        prev     = 1'b0;
        Samp_Ack = 1'b0;
        Samp_RGB = '0;
        forever begin
            @(posedge Clk);
            #1;
            Samp_Ack = 1'b0;
            if (gc) idx = 0;
            if (Samp_Req && !prev) begin
                wc    = 0;
                acked = 1'b0;
            end
            if (Samp_Req && !acked && idx < NS) begin
                if (waitTab[idx] == wc) begin
                    Samp_Ack = 1'b1;
                    Samp_RGB = rgbTab[idx];
                    acked    = 1'b1;
                end else begin
                    wc++;
                end
            end else if (!Samp_Req && prev) begin
                if (!acked && idx < NS && lateTab[idx]) begin
                    Samp_Ack = 1'b1;
                    Samp_RGB = '1;
                end
                idx++;
            end
            prev = Samp_Req;
        end
    end

    // Monitor: pops an expected request on every new Samp_Req, checks its
    // coordinates each cycle it is held and its length when it drops; pops
    // the expected face on every Done.
    initial begin : monitor
        req_t  cur;
        face_t f;
        bit    e;
        bit    active;
        bit    prevReq;
        bit    prevGc;
        bit    waitFirst;
        int    dur;
        int    gcCycle;
        active    = 1'b0;
        prevReq   = 1'b0;
        prevGc    = 1'b0;
        waitFirst = 1'b0;
        dur       = 0;
        gcCycle   = 0;
        forever begin
            @(negedge Clk);
            if (Reset_N !== 1'b1) begin
                active    = 1'b0;
                prevReq   = 1'b0;
                prevGc    = 1'b0;
                waitFirst = 1'b0;
            end else begin
                if (gc) begin
                    checkOutput("gc_single_cycle", prevGc, 0);
                    gcCycle   = cycle;
                    waitFirst = 1'b1;
                end
                if (Samp_Req && !prevReq) begin
                    reqSeen++;
                    if (waitFirst) begin
                        checkOutput("gc_to_first_req_ge2", ((cycle - gcCycle) >= 2), 1);
                        waitFirst = 1'b0;
                    end
                    checkOutput("req_expected", (expReqQ.size() > 0), 1);
                    if (expReqQ.size() > 0) begin
                        cur    = expReqQ.pop_front();
                        active = 1'b1;
                        dur    = 0;
                    end else begin
                        active = 1'b0;
                    end
                end
                if (Samp_Req && active) begin
                    dur++;
                    checkOutput("samp_x", Samp_X, cur.x);
                    checkOutput("samp_y", Samp_Y, cur.y);
                end
                if (!Samp_Req && prevReq && active) begin
                    checkOutput("req_high_cycles", dur, cur.dur);
                    active = 1'b0;
                end
                if (Done) begin
                    doneCount++;
                    doneCycle = cycle;
                    checkOutput("done_expected", (expFaceQ.size() > 0), 1);
                    if (expFaceQ.size() > 0) begin
                        f = expFaceQ.pop_front();
                        e = expErrQ.pop_front();
                        for (int b = 0; b < NUM_BLOCKS; b++) begin
                            checkOutput($sformatf("face_rgb[%0d]", b), Face_RGB[b], f[b]);
                        end
                        checkOutput("timeout_err", Timeout_Err, e);
                        checkOutput("busy_at_done", Busy, 1);
                    end
                end
                prevReq = Samp_Req;
                prevGc  = gc;
            end
        end
    end

    // Scenario sequence.
    initial begin : stimulus
        int lat;
        int startReq;
        int n;
        int blk;
        Reset_N  = 1'b0;
        Start    = 1'b0;
        CentersX = '0;
        CentersY = '0;
        for (int i = 0; i < NS; i++) begin
            rgbTab[i]  = '0;
            waitTab[i] = 0;
            lateTab[i] = 1'b0;
        end
        repeat (3) @(posedge Clk);
        doReset();

        // Regular grid from a 300-pixel cube at (100,50); constant colour.
        $display("[TB] scan 1: grid centres, constant colour, zero-wait ack");
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            cenX[b] = 150 + 100 * (b % 3);
            cenY[b] = 100 + 100 * (b / 3);
        end
        for (int i = 0; i < NS; i++) begin
            rgbTab[i]  = {10'd400, 10'd200, 10'd100};
            waitTab[i] = 0;
            lateTab[i] = 1'b0;
        end
        applyStimulus(600, 1'b0, lat);
        checkOutput("start_to_done_latency_74_to_78", (lat >= 74 && lat <= 78), 1);

        // Block 5 red channel 3,4,5,6 averages to 4 after truncation.
        $display("[TB] scan 2: random waits, block 5 truncating average");
        randomTables(3);
        for (int s = 0; s < 4; s++) rgbTab[16 + s] = {10'(3 + s), 20'd0};
        applyStimulus(800, 1'b0, lat);

        // Block 2 sub-sample 1 is never acked, then gets a stray late ack.
        $display("[TB] scan 3: timeout on block 2 sub-sample 1");
        randomTables(3);
        waitTab[5] = -1;
        lateTab[5] = 1'b1;
        applyStimulus(1200, 1'b0, lat);

        // Edge-of-frame centres and Start held high from mid-scan onwards.
        $display("[TB] scan 4: saturating coordinates, Start while busy");
        randomTables(2);
        blk        = $urandom_range(0, NUM_BLOCKS - 1);
        cenX[blk]  = 2047;
        cenY[(blk + 4) % NUM_BLOCKS] = 2047;
        applyStimulus(800, 1'b1, lat);

        // Reset while block 3 is being sampled.
        $display("[TB] scan 5: reset during block 3");
        randomTables(0);
        driveCenters();
        buildExpect();
        startReq = reqSeen;
        n        = 0;
        @(posedge Clk);
        #1;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        while (reqSeen < startReq + 9 && n < 200) begin
            @(posedge Clk);
            #1;
            n++;
        end
        checkOutput("reached_block3", (reqSeen >= startReq + 9), 1);
        doReset();

        // Clean scans after the reset.
        $display("[TB] scans 6-7: random clean scans");
        for (int k = 0; k < 2; k++) begin
            randomTables(5);
            applyStimulus(1000, 1'b0, lat);
        end

        repeat (5) @(posedge Clk);
        #1;
        checkOutput("all_requests_seen", expReqQ.size(), 0);
        checkOutput("total_done_pulses", doneCount, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
